kernel_launch_queue: RTL and testbench

Device-level kernel scheduler sitting in front of the GPU's DCR and dispatcher. Host pushes launch descriptors (kernel ID + thread count) into a small FIFO. The block runs each kernel in turn: it resets the cores and dispatcher, programs the DCR thread count, holds start until done, then reports completion with a cycle count and a timeout flag. This lets the host queue kernels without polling done between launches.

---
 rtl/kernel_launch_queue.sv | 156 +++++++++++++++
 tb/tb_kernel_launch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launch_queue.sv
// Kernel launch scheduler: queues launch descriptors and sequences each kernel
// through GPU reset, DCR programming and a start/done handshake, reporting a completion record.
module kernel_launch_queue #(
    parameter int unsigned ID_BITS        = 4,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         launch_valid,
    output logic                         launch_ready,
    input  logic [ID_BITS-1:0]           launch_id,
    input  logic [7:0]                   launch_thread_count,
    output logic                         gpu_reset,
    output logic                         dcr_write_enable,
    output logic [7:0]                   dcr_data,
    output logic                         gpu_start,
    input  logic                         gpu_done,
    output logic                         complete_valid,
    input  logic                         complete_ready,
    output logic [ID_BITS-1:0]           complete_id,
    output logic [15:0]                  complete_cycles,
    output logic                         complete_error,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         busy
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] FULL     = CW'(QUEUE_DEPTH);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [15:0]   TIMEOUT  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, RST, DCR, RUN, COMPLETE} state_t;

    state_t               state;
    logic [ID_BITS-1:0]   fifo_id [QUEUE_DEPTH];
    logic [7:0]           fifo_tc [QUEUE_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;
    logic [ID_BITS-1:0]   current_id;
    logic [7:0]           current_tc;
    logic [RW-1:0]        rst_cnt;
    logic                 rst_hold;
    logic [15:0]          run_next;

    // Readiness comes from the registered count only, so a pop never frees a slot for a same-cycle push.
    assign launch_ready = (queue_count != FULL);
    assign push         = launch_valid && launch_ready;
    assign pop          = (state == IDLE) && (queue_count != '0);
    assign gpu_reset    = reset | rst_hold;
    assign complete_id  = current_id;
    assign busy         = (state != IDLE) || (queue_count != '0);
    assign run_next     = (complete_cycles == 16'hFFFF) ? complete_cycles : complete_cycles + 16'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr] <= launch_id;
            fifo_tc[wr_ptr] <= launch_thread_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   queue_count <= queue_count + CW'(1);
                2'b01:   queue_count <= queue_count - CW'(1);
                default: queue_count <= queue_count;
            endcase
        end
    end

    // complete_cycles doubles as the RUN counter; it is frozen once COMPLETE is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            current_id       <= '0;
            current_tc       <= '0;
            rst_cnt          <= '0;
            rst_hold         <= 1'b0;
            dcr_write_enable <= 1'b0;
            dcr_data         <= '0;
            gpu_start        <= 1'b0;
            complete_valid   <= 1'b0;
            complete_cycles  <= '0;
            complete_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        current_id      <= fifo_id[rd_ptr];
                        current_tc      <= fifo_tc[rd_ptr];
                        complete_cycles <= '0;
                        complete_error  <= 1'b0;
                        if (fifo_tc[rd_ptr] == 8'd0) begin
                            state          <= COMPLETE;
                            complete_valid <= 1'b1;
                        end else begin
                            state    <= RST;
                            rst_hold <= 1'b1;
                            rst_cnt  <= '0;
                        end
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state            <= DCR;
                        rst_hold         <= 1'b0;
                        dcr_write_enable <= 1'b1;
                        dcr_data         <= current_tc;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                DCR: begin
                    state            <= RUN;
                    dcr_write_enable <= 1'b0;
                    dcr_data         <= '0;
                    gpu_start        <= 1'b1;
                    complete_cycles  <= '0;
                end
                RUN: begin
                    complete_cycles <= run_next;
                    if (gpu_done) begin
                        state          <= COMPLETE;
                        gpu_start      <= 1'b0;
                        complete_valid <= 1'b1;
                        complete_error <= 1'b0;
                    end else if ((TIMEOUT != 16'd0) && (run_next == TIMEOUT)) begin
                        state          <= COMPLETE;
                        gpu_start      <= 1'b0;
                        complete_valid <= 1'b1;
                        complete_error <= 1'b1;
                    end
                end
                COMPLETE: begin
                    if (complete_ready) begin
                        state          <= IDLE;
                        complete_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_launch_queue.sv
// Self-checking bench: transaction-level queue model plus per-kernel sequence checks
// against the launch/reset/DCR/run/complete rules.
module tb_kernel_launch_queue;
    localparam int QD = 4;
    localparam int RC = 2;
    localparam int TO = 20;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] tc;
    } desc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        launch_valid = 1'b0;
    logic        launch_ready;
    logic [3:0]  launch_id = '0;
    logic [7:0]  launch_thread_count = '0;
    logic        gpu_reset;
    logic        dcr_write_enable;
    logic [7:0]  dcr_data;
    logic        gpu_start;
    logic        gpu_done = 1'b0;
    logic        complete_valid;
    logic        complete_ready = 1'b0;
    logic [3:0]  complete_id;
    logic [15:0] complete_cycles;
    logic        complete_error;
    logic [2:0]  queue_count;
    logic        busy;

    kernel_launch_queue #(
        .ID_BITS(4),
        .QUEUE_DEPTH(QD),
        .RESET_CYCLES(RC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .launch_valid(launch_valid),
        .launch_ready(launch_ready),
        .launch_id(launch_id),
        .launch_thread_count(launch_thread_count),
        .gpu_reset(gpu_reset),
        .dcr_write_enable(dcr_write_enable),
        .dcr_data(dcr_data),
        .gpu_start(gpu_start),
        .gpu_done(gpu_done),
        .complete_valid(complete_valid),
        .complete_ready(complete_ready),
        .complete_id(complete_id),
        .complete_cycles(complete_cycles),
        .complete_error(complete_error),
        .queue_count(queue_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    push_prob = 100;
    desc_t to_push[$];
    desc_t m_fifo[$];
    desc_t cur;
    int    m_count = 0;
    bit    m_idle = 1'b1;
    bit    m_accept = 1'b0;
    bit    popped = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t mk(input int id, input int tc);
        desc_t r;
        r.id = 4'(id);
        r.tc = 8'(tc);
        return r;
    endfunction

    task automatic drive_push();
        if (to_push.size() > 0 && $urandom_range(1, 100) <= push_prob) begin
            launch_valid        = 1'b1;
            launch_id           = to_push[0].id;
            launch_thread_count = to_push[0].tc;
        end else begin
            launch_valid = 1'b0;
        end
    endtask

    // One clock: advance the queue model by the rules, then compare queue-facing outputs.
    task automatic tick();
        bit    do_push;
        bit    do_pop;
        desc_t d;
        do_push = launch_valid && (m_count != QD);
        do_pop  = m_idle && (m_count != 0);
        d.id = launch_id;
        d.tc = launch_thread_count;
        @(posedge clk);
        if (do_pop) begin
            cur    = m_fifo.pop_front();
            m_idle = 1'b0;
            popped = 1'b1;
        end
        if (do_push) begin
            m_fifo.push_back(d);
            to_push.delete(0);
        end
        if (m_accept) begin
            m_idle   = 1'b1;
            m_accept = 1'b0;
        end
        m_count = m_fifo.size();
        #1;
        check("queue_count", 32'(queue_count), 32'(m_count));
        check("launch_ready", 32'(launch_ready), 32'(m_count != QD));
        check("busy", 32'(busy), 32'(!m_idle || m_count != 0));
        drive_push();
    endtask

    task automatic run_one(input int done_k, input int ready_delay, input int abort_at);
        int   bound;
        int   idx;
        int   n_rst, first_rst, n_dcr, dcr_idx, n_start, first_start, exp_cycles;
        logic [7:0] dcr_val;
        bit   fin;
        bit   tmo;
        complete_ready = (ready_delay == 0);
        bound = 0;
        while (!popped && bound < 100) begin
            tick();
            bound++;
        end
        check("pop_seen", 32'(popped), 32'd1);
        if (!popped) return;
        popped = 1'b0;
        idx = 0; n_rst = 0; first_rst = 0; n_dcr = 0; dcr_idx = 0;
        n_start = 0; first_start = 0; dcr_val = '0; fin = 1'b0;
        while (!fin && idx < 200) begin
            idx++;
            if (complete_valid) begin
                fin = 1'b1;
            end else begin
                if (gpu_reset) begin
                    n_rst++;
                    if (first_rst == 0) first_rst = idx;
                end
                if (dcr_write_enable) begin
                    n_dcr++;
                    dcr_idx = idx;
                    dcr_val = dcr_data;
                end
                if (gpu_start) begin
                    n_start++;
                    if (first_start == 0) first_start = idx;
                end
                check("start_reset_overlap", 32'(gpu_start && gpu_reset), 32'd0);
                if (abort_at != 0 && n_start == abort_at) begin
                    reset        = 1'b1;
                    launch_valid = 1'b0;
                    gpu_done     = 1'b0;
                    @(posedge clk);
                    #1;
                    check("rst_gpu_start", 32'(gpu_start), 32'd0);
                    check("rst_gpu_reset", 32'(gpu_reset), 32'd1);
                    check("rst_queue_count", 32'(queue_count), 32'd0);
                    check("rst_complete_valid", 32'(complete_valid), 32'd0);
                    check("rst_launch_ready", 32'(launch_ready), 32'd1);
                    check("rst_busy", 32'(busy), 32'd0);
                    m_fifo.delete();
                    to_push.delete();
                    m_count = 0;
                    m_idle  = 1'b1;
                    popped  = 1'b0;
                    reset   = 1'b0;
                    @(posedge clk);
                    #1;
                    check("post_rst_gpu_reset", 32'(gpu_reset), 32'd0);
                    return;
                end
                gpu_done = gpu_start ? (n_start == done_k) : 1'($urandom_range(0, 1));
                tick();
            end
        end
        gpu_done = 1'b0;
        check("complete_seen", 32'(fin), 32'd1);
        tmo        = (cur.tc != 0) && (done_k == 0 || done_k > TO);
        exp_cycles = (cur.tc == 0) ? 0 : (tmo ? TO : done_k);
        if (cur.tc == 0) begin
            check("zt_latency", 32'(idx), 32'd1);
            check("zt_resets", 32'(n_rst), 32'd0);
            check("zt_dcr", 32'(n_dcr), 32'd0);
            check("zt_starts", 32'(n_start), 32'd0);
        end else begin
            check("reset_cycles", 32'(n_rst), 32'(RC));
            check("reset_first", 32'(first_rst), 32'd1);
            check("dcr_writes", 32'(n_dcr), 32'd1);
            check("dcr_index", 32'(dcr_idx), 32'(RC + 1));
            check("dcr_data", 32'(dcr_val), 32'(cur.tc));
            check("start_first", 32'(first_start), 32'(RC + 2));
            check("start_cycles", 32'(n_start), 32'(exp_cycles));
            check("complete_index", 32'(idx), 32'(RC + 2 + exp_cycles));
        end
        check("rec_id", 32'(complete_id), 32'(cur.id));
        check("rec_cycles", 32'(complete_cycles), 32'(exp_cycles));
        check("rec_error", 32'(complete_error), 32'(tmo));
        for (int d = 1; d < ready_delay; d++) begin
            gpu_done = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", 32'(complete_valid), 32'd1);
            check("hold_id", 32'(complete_id), 32'(cur.id));
            check("hold_cycles", 32'(complete_cycles), 32'(exp_cycles));
            check("hold_error", 32'(complete_error), 32'(tmo));
            check("hold_strobes", 32'({gpu_start, gpu_reset, dcr_write_enable}), 32'd0);
        end
        gpu_done       = 1'b0;
        complete_ready = 1'b1;
        m_accept       = 1'b1;
        tick();
        check("accepted", 32'(complete_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_gpu_reset", 32'(gpu_reset), 32'd1);
        check("reset_launch_ready", 32'(launch_ready), 32'd1);
        check("reset_queue_count", 32'(queue_count), 32'd0);
        check("reset_outputs", 32'({dcr_write_enable, gpu_start, complete_valid, complete_error, busy}), 32'd0);
        check("reset_dcr_data", 32'(dcr_data), 32'd0);
        check("reset_complete_id", 32'(complete_id), 32'd0);
        check("reset_complete_cycles", 32'(complete_cycles), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_gpu_reset", 32'(gpu_reset), 32'd0);

        // single launch
        push_prob = 100;
        to_push.push_back(mk(3, 8));
        drive_push();
        run_one(10, 0, 0);

        // back-to-back, ready held high; third kernel has done and timeout together
        to_push.push_back(mk(1, $urandom_range(1, 255)));
        to_push.push_back(mk(2, $urandom_range(1, 255)));
        to_push.push_back(mk(3, $urandom_range(1, 255)));
        drive_push();
        run_one($urandom_range(1, 15), 0, 0);
        run_one($urandom_range(1, 15), 0, 0);
        run_one(TO, 0, 0);

        // full queue behind a stalled kernel that times out
        for (int i = 0; i < 6; i++) to_push.push_back(mk(4 + i, $urandom_range(1, 255)));
        drive_push();
        run_one(0, 0, 0);
        for (int i = 0; i < 5; i++) run_one($urandom_range(1, 12), $urandom_range(0, 2), 0);

        // zero threads with backpressure
        to_push.push_back(mk(12, 0));
        drive_push();
        run_one(0, 5, 0);

        // reset in the 4th RUN cycle with more kernels queued
        to_push.push_back(mk(10, 5));
        to_push.push_back(mk(11, 6));
        to_push.push_back(mk(13, 7));
        drive_push();
        run_one(0, 0, 4);

        // randomized mix
        push_prob = 40;
        for (int i = 0; i < 14; i++)
            to_push.push_back(mk($urandom_range(0, 15),
                                 ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255)));
        drive_push();
        for (int i = 0; i < 14; i++) run_one($urandom_range(0, 24), $urandom_range(0, 3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
